// File: rtl/viterbi_metric_bank.sv
// viterbi_metric_bank
// Double-buffered path-metric store for the Viterbi datapath. One bank is
// written with the new column while the other is read; a sequential arg-max
// scanner walks the read bank to find the strongest tag for backtrace start.
//
// Scanner states
//   state   | meaning
//   ST_IDLE | waiting for find_start; swap is honoured here only
//   ST_SCAN | comparing read-bank entry scan_idx against the running best
//   ST_DONE | find_done pulse; result already latched in max_index/max_value
module viterbi_metric_bank #(
  parameter int P_SIZE      = 32,
  parameter int POS_NUM     = 11,
  parameter int POS_NUM_BIT = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        load,
  input  logic [POS_NUM*P_SIZE-1:0]   p_in,
  input  logic                        swap,
  input  logic [POS_NUM_BIT-1:0]      chose_index,
  output logic [P_SIZE-1:0]           p_out,
  input  logic                        find_start,
  output logic                        find_busy,
  output logic                        find_done,
  output logic [POS_NUM_BIT-1:0]      max_index,
  output logic [P_SIZE-1:0]           max_value
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [POS_NUM_BIT-1:0] LAST_IDX = POS_NUM_BIT'(POS_NUM - 1);
  localparam logic [POS_NUM_BIT-1:0] IDX_ONE  = POS_NUM_BIT'(1);

  logic [P_SIZE-1:0]      bank0   [POS_NUM];
  logic [P_SIZE-1:0]      bank1   [POS_NUM];
  logic [P_SIZE-1:0]      rd_bank [POS_NUM];
  logic                   bank_sel;

  state_t                 state;
  state_t                 nxt_state;
  logic [POS_NUM_BIT-1:0] scan_idx;
  logic [POS_NUM_BIT-1:0] nxt_scan_idx;
  logic [P_SIZE-1:0]      best_val;
  logic [P_SIZE-1:0]      nxt_best_val;
  logic [POS_NUM_BIT-1:0] best_idx;
  logic [POS_NUM_BIT-1:0] nxt_best_idx;
  logic [POS_NUM_BIT-1:0] max_index_q;
  logic [POS_NUM_BIT-1:0] nxt_max_index;
  logic [P_SIZE-1:0]      max_value_q;
  logic [P_SIZE-1:0]      nxt_max_value;
  logic [P_SIZE-1:0]      scan_val;
  logic                   swap_ok;

  // Swaps are dropped while a scan is running so the scanned column stays put.
  assign swap_ok = swap && !find_busy;

  // Bank storage: load fills the current write bank; bank_sel flips on an accepted swap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < POS_NUM; k++) begin
        bank0[k] <= '0;
        bank1[k] <= '0;
      end
      bank_sel <= 1'b0;
    end else begin
      if (load) begin
        for (int k = 0; k < POS_NUM; k++) begin
          if (bank_sel) begin
            bank0[k] <= p_in[k*P_SIZE +: P_SIZE];
          end else begin
            bank1[k] <= p_in[k*P_SIZE +: P_SIZE];
          end
        end
      end
      if (swap_ok) begin
        bank_sel <= ~bank_sel;
      end
    end
  end

  // Present whichever bank is currently the read bank.
  always_comb begin
    for (int k = 0; k < POS_NUM; k++) begin
      rd_bank[k] = bank_sel ? bank1[k] : bank0[k];
    end
  end

  // External read port; indices beyond the last tag read as zero.
  always_comb begin
    p_out = '0;
    for (int k = 0; k < POS_NUM; k++) begin
      if (chose_index == POS_NUM_BIT'(k)) begin
        p_out = rd_bank[k];
      end
    end
  end

  // Scanner read port, addressed by the running scan index.
  always_comb begin
    scan_val = '0;
    for (int k = 0; k < POS_NUM; k++) begin
      if (scan_idx == POS_NUM_BIT'(k)) begin
        scan_val = rd_bank[k];
      end
    end
  end

  // Scanner state and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      scan_idx    <= '0;
      best_val    <= '0;
      best_idx    <= '0;
      max_index_q <= '0;
      max_value_q <= '0;
    end else begin
      state       <= nxt_state;
      scan_idx    <= nxt_scan_idx;
      best_val    <= nxt_best_val;
      best_idx    <= nxt_best_idx;
      max_index_q <= nxt_max_index;
      max_value_q <= nxt_max_value;
    end
  end

  // Scanner next-state and outputs. The result is latched on the edge that
  // compares the last entry, so it is valid together with find_done.
  always_comb begin
    nxt_state     = state;
    nxt_scan_idx  = scan_idx;
    nxt_best_val  = best_val;
    nxt_best_idx  = best_idx;
    nxt_max_index = max_index_q;
    nxt_max_value = max_value_q;
    find_busy     = 1'b0;
    find_done     = 1'b0;

    case (state)
      ST_IDLE: begin
        if (find_start) begin
          nxt_scan_idx = IDX_ONE;
          nxt_best_val = rd_bank[0];
          nxt_best_idx = '0;
          nxt_state    = ST_SCAN;
        end
      end

      ST_SCAN: begin
        find_busy = 1'b1;
        // Strictly greater keeps the lowest index on ties.
        if (scan_val > best_val) begin
          nxt_best_val = scan_val;
          nxt_best_idx = scan_idx;
        end
        nxt_scan_idx = scan_idx + IDX_ONE;
        if (scan_idx == LAST_IDX) begin
          nxt_max_value = nxt_best_val;
          nxt_max_index = nxt_best_idx;
          nxt_state     = ST_DONE;
        end
      end

      ST_DONE: begin
        find_busy = 1'b1;
        find_done = 1'b1;
        nxt_state = ST_IDLE;
      end

      default: begin
        nxt_state = ST_IDLE;
      end
    endcase
  end

  assign max_index = max_index_q;
  assign max_value = max_value_q;

endmodule

// File: tb/tb_viterbi_metric_bank.sv
// tb_viterbi_metric_bank
// Directed bench for the double-buffered metric bank and arg-max scanner.
module tb_viterbi_metric_bank;

  localparam int P_SIZE      = 32;
  localparam int POS_NUM     = 11;
  localparam int POS_NUM_BIT = 4;

  logic                      clk;
  logic                      reset;
  logic                      load;
  logic [POS_NUM*P_SIZE-1:0] p_in;
  logic                      swap;
  logic [POS_NUM_BIT-1:0]    chose_index;
  logic [P_SIZE-1:0]         p_out;
  logic                      find_start;
  logic                      find_busy;
  logic                      find_done;
  logic [POS_NUM_BIT-1:0]    max_index;
  logic [P_SIZE-1:0]         max_value;

  int n_checks = 0;
  int n_errors = 0;

  logic [P_SIZE-1:0] col [POS_NUM];

  viterbi_metric_bank #(
    .P_SIZE      (P_SIZE),
    .POS_NUM     (POS_NUM),
    .POS_NUM_BIT (POS_NUM_BIT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .load        (load),
    .p_in        (p_in),
    .swap        (swap),
    .chose_index (chose_index),
    .p_out       (p_out),
    .find_start  (find_start),
    .find_busy   (find_busy),
    .find_done   (find_done),
    .max_index   (max_index),
    .max_value   (max_value)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_pout(input string tag, input int idx, input logic [63:0] exp);
    chose_index = POS_NUM_BIT'(idx);
    #1;
    chk(tag, {32'd0, p_out}, exp);
  endtask

  // Drive the global column onto p_in for one edge, optionally with swap.
  task automatic load_col(input logic sw);
    for (int k = 0; k < POS_NUM; k++) p_in[k*P_SIZE +: P_SIZE] = col[k];
    load = 1'b1;
    swap = sw;
    tick();
    load = 1'b0;
    swap = 1'b0;
  endtask

  task automatic do_swap();
    swap = 1'b1;
    tick();
    swap = 1'b0;
  endtask

  // Start a scan and return the number of edges until find_done (-1 on timeout),
  // leaving the scanner back in idle.
  task automatic run_scan(output int lat);
    find_start = 1'b1;
    tick();
    find_start = 1'b0;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (find_done) begin
        lat = i;
        break;
      end
    end
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    int done_cnt;
    int done_at [3];
    logic stable;

    reset = 1'b1;
    load = 1'b0;
    swap = 1'b0;
    find_start = 1'b0;
    chose_index = '0;
    p_in = '0;
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    chk("rst_busy", find_busy, 0);
    chk("rst_done", find_done, 0);
    chk("rst_max_index", max_index, 0);
    chk("rst_max_value", max_value, 0);
    chk_pout("rst_pout0", 0, 0);

    // Ping-pong
    for (int k = 0; k < POS_NUM; k++) col[k] = k * 100 + k;
    load_col(1'b0);
    chk_pout("pp_before_swap", 3, 0);
    do_swap();
    chk_pout("pp_first", 3, 303);
    for (int k = 0; k < POS_NUM; k++) col[k] = 1000 + k;
    load_col(1'b0);
    chk_pout("pp_write_isolated", 3, 303);
    do_swap();
    chk_pout("pp_second", 3, 1003);

    // Load and swap in the same cycle
    for (int k = 0; k < POS_NUM; k++) col[k] = k + 7;
    load_col(1'b1);
    chk_pout("ls_entry5", 5, 12);
    chk_pout("ls_entry0", 0, 7);
    chk_pout("ls_entry10", 10, 17);
    chk_pout("ls_oob11", 11, 0);
    chk_pout("ls_oob12", 12, 0);
    chk_pout("ls_oob15", 15, 0);

    // Arg-max with a tie between entries 1 and 3
    col = '{5, 9, 2, 9, 3, 4, 6, 0, 7, 8, 1};
    load_col(1'b1);
    run_scan(lat);
    chk("am_latency", lat, 10);
    chk("am_tie_index", max_index, 1);
    chk("am_tie_value", max_value, 9);
    chk("am_idle_busy", find_busy, 0);
    chk("am_idle_done", find_done, 0);

    // Unsigned compare: all-ones must beat small positives
    col[4] = 32'hFFFF_FFFF;
    load_col(1'b1);
    run_scan(lat);
    chk("us_latency", lat, 10);
    chk("us_index", max_index, 4);
    chk("us_value", max_value, 64'hFFFF_FFFF);

    // Maximum in the last entry
    col = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 500};
    load_col(1'b1);
    run_scan(lat);
    chk("last_index", max_index, 10);
    chk("last_value", max_value, 500);

    // Swap attempted during a scan must be ignored
    col = '{20, 20, 20, 20, 20, 20, 20, 900, 900, 20, 20};
    load_col(1'b0);
    find_start = 1'b1;
    tick();
    find_start = 1'b0;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      swap = (i >= 2 && i <= 5);
      tick();
      if (find_done) begin
        lat = i;
        break;
      end
    end
    swap = 1'b0;
    tick();
    chk("sb_latency", lat, 10);
    chk("sb_index", max_index, 10);
    chk("sb_value", max_value, 500);
    chk_pout("sb_bank_kept", 10, 500);
    do_swap();
    chk_pout("sb_swap_after", 7, 900);
    run_scan(lat);
    chk("sb_new_index", max_index, 7);
    chk("sb_new_value", max_value, 900);

    // find_start held high: accepted only from idle, one result every 12 edges
    done_cnt = 0;
    stable = 1'b1;
    find_start = 1'b1;
    for (int e = 1; e <= 40; e++) begin
      tick();
      if (find_done) begin
        if (done_cnt < 3) done_at[done_cnt] = e;
        done_cnt++;
      end
      if (max_index !== 4'd7 || max_value !== 32'd900) stable = 1'b0;
    end
    find_start = 1'b0;
    chk("rep_done_count", done_cnt, 3);
    chk("rep_first_done", done_at[0], 11);
    chk("rep_spacing1", done_at[1] - done_at[0], 12);
    chk("rep_spacing2", done_at[2] - done_at[1], 12);
    chk("rep_stable", stable, 1);
    for (int i = 0; i < 30 && find_busy; i++) tick();
    chk("rep_drained", find_busy, 0);

    // Reset in the middle of a scan
    find_start = 1'b1;
    tick();
    find_start = 1'b0;
    tick();
    tick();
    tick();
    chk("mr_busy_before", find_busy, 1);
    reset = 1'b1;
    #1;
    chk("mr_busy", find_busy, 0);
    chk("mr_done", find_done, 0);
    chk("mr_max_index", max_index, 0);
    chk("mr_max_value", max_value, 0);
    for (int k = 0; k < 16; k++) chk_pout("mr_pout", k, 0);
    tick();
    tick();
    reset = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (find_done || find_busy) done_cnt++;
    end
    chk("mr_no_done", done_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
